// File: rtl/xorwow_rng_array.sv
`default_nettype none
// ============================================================================
// Module   : xorwow_rng_array
// Purpose  : NUM_LANES parallel single-cycle xorwow generators with a
//            valid/ready output stage and run-time re-seeding. Optional macro
//            XORWOW_RANGE_EN scales each lane word into [0, range_max).
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module xorwow_rng_array #(
    parameter int          NUM_LANES    = 4,
    parameter logic [31:0] SEED_DEFAULT = 32'h0000_0000,
    parameter logic [31:0] LANE_MIX     = 32'h9E37_79B9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      seed_load,
    input  logic [31:0]               seed_data,
`ifdef XORWOW_RANGE_EN
    input  logic [31:0]               range_max,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [32*NUM_LANES-1:0]   out_data
);

    localparam logic [31:0] C_INIT_X   = 32'd123456789;
    localparam logic [31:0] C_INIT_Y   = 32'd362436069;
    localparam logic [31:0] C_INIT_Z   = 32'd521288629;
    localparam logic [31:0] C_INIT_W   = 32'd88675123;
    localparam logic [31:0] C_INIT_V   = 32'd5783321;
    localparam logic [31:0] C_INIT_D   = 32'd6615241;
    localparam logic [31:0] C_D_STRIDE = 32'd362437;

    logic        r_valid;
    logic        w_advance;
    logic        w_reseed;
    logic [31:0] w_seed;

    // out_valid is purely registered, so advance never loops back through it
    assign w_advance = en & (~r_valid | out_ready);
    assign w_reseed  = rst | seed_load;
    assign w_seed    = rst ? SEED_DEFAULT : seed_data;
    assign out_valid = r_valid;

    always_ff @(posedge clk) begin
        if (w_reseed) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [31:0] C_LANE_KEY = 32'(i) * LANE_MIX;

        logic [31:0] r_x, r_y, r_z, r_w, r_v, r_d;
        logic [31:0] r_word;
        logic [31:0] w_key;
        logic [31:0] w_t;
        logic [31:0] w_v_next;
        logic [31:0] w_d_next;
        logic [31:0] w_raw;
        logic [31:0] w_word;

        assign w_key    = w_seed ^ C_LANE_KEY;
        assign w_t      = r_x ^ (r_x >> 2);
        assign w_v_next = (r_v ^ (r_v << 4)) ^ (w_t ^ (w_t << 1));
        assign w_d_next = r_d + C_D_STRIDE;
        assign w_raw    = w_d_next + w_v_next;

`ifdef XORWOW_RANGE_EN
        // Upper half of the 64-bit product maps the raw word onto [0, range_max)
        assign w_word = 32'((64'(w_raw) * 64'(range_max)) >> 32);
`else
        assign w_word = w_raw;
`endif

        always_ff @(posedge clk) begin
            if (w_reseed) begin
                r_x <= C_INIT_X ^ w_key;
                r_y <= C_INIT_Y;
                r_z <= C_INIT_Z;
                r_w <= C_INIT_W;
                r_v <= C_INIT_V;
                r_d <= C_INIT_D + w_key;
            end else if (w_advance) begin
                r_x <= r_y;
                r_y <= r_z;
                r_z <= r_w;
                r_w <= r_v;
                r_v <= w_v_next;
                r_d <= w_d_next;
            end
        end

        // A seed pulse discards the pending word but leaves the last value visible
        always_ff @(posedge clk) begin
            if (rst) begin
                r_word <= 32'h0000_0000;
            end else if (!seed_load && w_advance) begin
                r_word <= w_word;
            end
        end

        assign out_data[32*i +: 32] = r_word;
    end

endmodule
`default_nettype wire

// File: tb/tb_xorwow_rng_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_xorwow_rng_array
// Purpose  : Self-checking bench for xorwow_rng_array against a cycle-level
//            reference model of the generator and its handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xorwow_rng_array;

    localparam int          NL       = 4;
    localparam logic [31:0] LANE_MIX = 32'h9E37_79B9;
    localparam logic [31:0] SEED_DEF = 32'h0000_0000;
    localparam int          DW       = 32 * NL;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          seed_load;
    logic [31:0]   seed_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   rmax;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    int unsigned   mx [NL];
    int unsigned   my [NL];
    int unsigned   mz [NL];
    int unsigned   mw [NL];
    int unsigned   mv [NL];
    int unsigned   md [NL];
    bit            m_valid;
    logic [DW-1:0] m_data;

    xorwow_rng_array #(
        .NUM_LANES    (NL),
        .SEED_DEFAULT (SEED_DEF),
        .LANE_MIX     (LANE_MIX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seed_load (seed_load),
        .seed_data (seed_data),
`ifdef XORWOW_RANGE_EN
        .range_max (rmax),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_seed(input logic [31:0] s);
        int unsigned k;
        for (int i = 0; i < NL; i++) begin
            k     = s ^ (32'(i) * LANE_MIX);
            mx[i] = 32'd123456789 ^ k;
            my[i] = 32'd362436069;
            mz[i] = 32'd521288629;
            mw[i] = 32'd88675123;
            mv[i] = 32'd5783321;
            md[i] = 32'd6615241 + k;
        end
    endtask

    function automatic logic [31:0] scale(input int unsigned raw);
`ifdef XORWOW_RANGE_EN
        longint unsigned p;
        p = longint'(raw) * longint'(rmax);
        return 32'(p >> 32);
`else
        return raw;
`endif
    endfunction

    task automatic model_step();
        int unsigned t, vn, dn;
        for (int i = 0; i < NL; i++) begin
            t  = mx[i] ^ (mx[i] >> 2);
            vn = (mv[i] ^ (mv[i] << 4)) ^ (t ^ (t << 1));
            dn = md[i] + 32'd362437;
            mx[i] = my[i];
            my[i] = mz[i];
            mz[i] = mw[i];
            mw[i] = mv[i];
            mv[i] = vn;
            md[i] = dn;
            m_data[32*i +: 32] = scale(dn + vn);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic cycle(input bit r, input bit e, input bit rd, input bit sl, input logic [31:0] sd);
        bit adv;
        rst       = r;
        en        = e;
        out_ready = rd;
        seed_load = sl;
        seed_data = sd;
        adv = e && (!m_valid || rd);
        if (r) begin
            model_seed(SEED_DEF);
            m_valid = 1'b0;
            m_data  = '0;
        end else if (sl) begin
            model_seed(sd);
            m_valid = 1'b0;
        end else if (adv) begin
            model_step();
            m_valid = 1'b1;
        end else if (rd) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("out_valid", DW'(out_valid), DW'(m_valid));
        check("out_data", out_data, m_data);
    endtask

    initial begin
        logic [DW-1:0] held;
        rmax    = 32'hFFFF_FFFF;
        m_valid = 1'b0;
        m_data  = '0;
        model_seed(SEED_DEF);

        // Reset state
        cycle(1, 0, 0, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);

`ifdef XORWOW_RANGE_EN
        rmax = 32'd10;
        cycle(0, 1, 1, 0, 32'h0);
        check("range10_lane0_first", DW'(out_data[31:0]), DW'(32'd0));
        for (int c = 0; c < 50; c++) begin
            for (int i = 0; i < NL; i++)
                check("range10_bound", DW'(out_data[32*i +: 32] < 32'd10), DW'(1'b1));
            cycle(0, 1, 1, 0, 32'h0);
        end
        rmax = 32'd0;
        for (int c = 0; c < 5; c++) begin
            cycle(0, 1, 1, 0, 32'h0);
            check("range0_zero", out_data, '0);
        end
        rmax = 32'hFFFF_FFFF;
        cycle(1, 0, 0, 0, 32'h0);
`endif

        // First word set after reset, then continuous streaming
        cycle(0, 1, 1, 0, 32'h0);
`ifndef XORWOW_RANGE_EN
        check("first_lane0", DW'(out_data[31:0]), DW'(32'h0EB7_0507));
        for (int a = 0; a < NL; a++)
            for (int b = a + 1; b < NL; b++) begin
                vectors++;
                assert (out_data[32*a +: 32] !== out_data[32*b +: 32]) else begin
                    miscompares++;
                    $error("FAIL lanes_distinct: lane%0d=%h lane%0d=%h", a,
                           out_data[32*a +: 32], b, out_data[32*b +: 32]);
                end
            end
`endif
        for (int c = 1; c < 1000; c++) cycle(0, 1, 1, 0, 32'h0);

        // Backpressure: everything must freeze
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            cycle(0, 1, 0, 0, 32'h0);
            check("bp_hold", out_data, held);
        end
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);

        // Seed pulse while a word is pending and being accepted
        cycle(0, 1, 1, 1, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
`ifndef XORWOW_RANGE_EN
        check("reseed_lane0", DW'(out_data[31:0]), DW'(32'h0EB7_0507));
`endif

        // Enable toggling 1,0,0,1
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);

        // Randomised traffic with occasional reseeds
        for (int c = 0; c < 400; c++) begin
`ifdef XORWOW_RANGE_EN
            rmax = $urandom;
`endif
            cycle(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0), 32'($urandom));
        end

        // Reset mid-stream
        cycle(0, 1, 1, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);
        check("midrst_data", out_data, '0);
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xorwow_rng_array.md
Name: xorwow_rng_array

Overview:
- Parametrised, multi-lane successor to the single-lane 3-cycle xorwow generator.
- NUM_LANES independent xorwow cores each advance in one cycle, giving NUM_LANES 32-bit words per cycle.
- Output uses a valid/ready handshake, and each lane can be re-seeded at run time.
- Feeds stochastic mutation/selection logic in the NEAT datapath.

Parameters:
- NUM_LANES, 4, number of independent generator lanes (1..16).
- SEED_DEFAULT, 32'h00000000, seed applied by reset.
- LANE_MIX, 32'h9E3779B9, per-lane decorrelation constant.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  generation enable.
- seed_load  input  1  one-cycle pulse; re-seeds all lanes from seed_data.
- seed_data  input  32  seed value used on seed_load.
- out_valid  output  1  out_data holds an unconsumed word set.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  32*NUM_LANES  lane i is at bits [32*i+31 : 32*i].

Behaviour:
- Per-lane state: x, y, z, w, v, d, each 32 bits.
- Constants: INIT_X=123456789, INIT_Y=362436069, INIT_Z=521288629, INIT_W=88675123, INIT_V=5783321, INIT_D=6615241, D_STRIDE=362437.
- Seeding with s:
  - Lane key k_i = s ^ (i*LANE_MIX), computed mod 2^32.
  - x=INIT_X^k_i, y=INIT_Y, z=INIT_Z, w=INIT_W, v=INIT_V, d=INIT_D+k_i (mod 2^32).
  - y..v are never all zero, so no degenerate state exists.
- Step, single cycle, all arithmetic mod 2^32, shifts logical:
  - t=x^(x>>2); v'=(v^(v<<4))^(t^(t<<1)); d'=d+D_STRIDE.
  - x<=y, y<=z, z<=w, w<=v, v<=v', d<=d'.
  - Lane word = d'+v', using the updated values.
- advance = en & (!out_valid | out_ready).
  - When advance is high, all lanes step and out_data takes the lane words.
  - out_valid is set to 1 on advance.
- out_valid clears when out_ready=1 and advance=0 (en low).
- While out_valid=1 and out_ready=0, out_data and all lane state hold stable.
- Latency: the first valid word set appears on the cycle after the first cycle with en=1 after reset or seed.
- seed_load has priority over advance in the same cycle:
  - All lanes are re-seeded and out_valid is forced to 0.
  - A pending word is discarded, even if out_ready=1 that cycle.
- Reset, including mid-operation:
  - All lanes seeded with SEED_DEFAULT.
  - out_valid=0, out_data=0.
- No FSM beyond the out_valid flag.
- out_data is registered; no combinational path from out_ready to out_data.
- out_valid depends only on registers.

Optional Feature:
- Macro XORWOW_RANGE_EN.
- When defined:
  - Adds input range_max [31:0].
  - Each lane word is replaced by (raw*range_max)>>32, an unsigned 64-bit product taking the upper 32 bits, giving a value in [0, range_max).
  - range_max=0 yields 0.
  - The scaling is computed combinationally before the out_data register, so latency is unchanged.
  - range_max is sampled on the advance cycle.
- When undefined: the port is absent and raw words are output.

Test Plan:
- Reset, then en=1, out_ready=1, NUM_LANES=4 -> first out_valid cycle lane0=32'h0EB70507 (standard xorwow first output); lanes 1-3 differ from lane0 and from each other.
- Continuous en=1, out_ready=1 for 1000 cycles -> a new word set every cycle; lane0 matches a software xorwow model for all 1000 words.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> out_data/out_valid stable; on release, the next word equals the model's next value (no skip, no duplicate).
- seed_load with seed_data=0 asserted alongside out_valid=1, out_ready=1 -> out_valid=0 next cycle; the following word set equals the post-reset first word set (lane0=32'h0EB70507).
- en toggling 1,0,0,1 with out_ready=1 -> out_valid drops while en=0; the model sequence continues without gaps.
- XORWOW_RANGE_EN defined:
  - range_max=10 -> every lane value in 0..9; lane0 first value = (0x0EB70507*10)>>32 = 0.
  - range_max=0 -> all zeros.
